pulse_handshake_tx: RTL

Source-side pulse transmitter for crossing single-cycle events into a foreign clock domain. Each `pulse_i` strobe in the `clk` domain becomes a four-phase request/acknowledge exchange on `req_o`/`ack_i`. The receiving domain's edge detector turns the held `req_o` level into exactly one pulse. This block sits at the sender end of every pflink pulse crossing and replaces free-running stretchers, so no event is lost silently.

---
 rtl/pflink_pulse_pkg.sv | 10 +
 rtl/sync_bit.sv | 19 +
 rtl/pulse_handshake_tx.sv | 103 ++++++++++
 3 files changed

// File: rtl/pflink_pulse_pkg.sv
// Shared types for the pflink pulse crossing: handshake state encoding and counter width.
package pflink_pulse_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RELEASE = 2'd2
  } phState_e;

  localparam int PULSE_TO_W = 16;
endpackage

// File: rtl/sync_bit.sv
// Two-flop level synchronizer with synchronous active-high reset.
module sync_bit (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/pulse_handshake_tx.sv
// Sender side of a pulse crossing: each clk-domain strobe becomes a four-phase req/ack exchange.
// Optional event queue enabled by PULSE_HANDSHAKE_TX_QUEUE_EN; default build drops pulses while busy.
module pulse_handshake_tx
  import pflink_pulse_pkg::*;
#(
  parameter int MIN_WIDTH = 4,
  parameter int TIMEOUT   = 1024,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pulse_i,
  input  logic             ack_i,
  output logic             req_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             drop_o,
  output logic             err_o,
  output logic [CNT_W-1:0] pending_o
);
  localparam logic [PULSE_TO_W-1:0] MIN_L = PULSE_TO_W'(MIN_WIDTH);
  localparam logic [PULSE_TO_W-1:0] TO_L  = PULSE_TO_W'(TIMEOUT);

  phState_e              state, stateNxt;
  logic                  ackS;
  logic [PULSE_TO_W-1:0] stCnt;
  logic                  havePend, take, busyPulse, toHit;
  logic                  doneNxt, errNxt, dropNxt;

  sync_bit uAckSync (.clk(clk), .rst(rst), .d(ack_i), .q(ackS));

  // One age counter serves as both width and timeout count: 1 on the entry cycle.
  assign toHit  = (TO_L != '0) && (stCnt == TO_L);
  assign busy_o = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      stCnt <= '0;
    end else begin
      state <= stateNxt;
      if (stateNxt != state)  stCnt <= PULSE_TO_W'(1);
      else if (stCnt != '1)   stCnt <= stCnt + PULSE_TO_W'(1);
    end
  end

  always_comb begin
    stateNxt = state;
    case (state)
      IDLE:    if (pulse_i || havePend) stateNxt = REQ;
      REQ:     if (ackS && stCnt >= MIN_L) stateNxt = RELEASE;
               else if (toHit)             stateNxt = IDLE;
      RELEASE: if (!ackS)     stateNxt = (pulse_i || havePend) ? REQ : IDLE;
               else if (toHit) stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
  end

  always_comb begin
    take      = (state != REQ) && (stateNxt == REQ);
    busyPulse = pulse_i && !take;
    doneNxt   = (state == RELEASE) && !ackS;
    errNxt    = toHit && (((state == REQ) && (stateNxt == IDLE)) ||
                          ((state == RELEASE) && ackS));
  end

`ifdef PULSE_HANDSHAKE_TX_QUEUE_EN
  localparam logic [CNT_W-1:0] PEND_MAX = '1;
  logic [CNT_W-1:0] pend;
  logic             fromPend, incOk;

  // Pulse has priority over the queue when both could start a handshake.
  assign fromPend = take && !pulse_i;
  assign incOk    = busyPulse && (pend != PEND_MAX);
  assign havePend = (pend != '0);
  assign dropNxt  = busyPulse && (pend == PEND_MAX) && !fromPend;
  assign pending_o = pend;

  always_ff @(posedge clk) begin
    if (rst)                         pend <= '0;
    else if (incOk && !fromPend)     pend <= pend + CNT_W'(1);
    else if (fromPend && !busyPulse) pend <= pend - CNT_W'(1);
  end
`else
  assign havePend  = 1'b0;
  assign dropNxt   = busyPulse;
  assign pending_o = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      req_o  <= 1'b0;
      done_o <= 1'b0;
      drop_o <= 1'b0;
      err_o  <= 1'b0;
    end else begin
      req_o  <= (stateNxt == REQ);
      done_o <= doneNxt;
      drop_o <= dropNxt;
      err_o  <= errNxt;
    end
  end
endmodule
